// File: rtl/axi_slave_mem.sv
// AXI4 slave endpoint backed by a word-addressed memory. Independent write
// (AW/W/B) and read (AR/R) engines, each with one outstanding burst.
module axi_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [ID_WIDTH-1:0]       BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ID_WIDTH-1:0]       ARID,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [1:0]                ARBURST,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [ID_WIDTH-1:0]       RID,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr, input logic [1:0] burst);
        logic [IDX_W:0] idx;
        idx = {1'b0, addr[ADDR_WIDTH-1:OFF_W]};
        return (idx < DEPTH_W) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

    function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFF_W +: MEM_AW];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr, input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + ADDR_WIDTH'(STRB_W) : addr;
    endfunction

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d, w_beat_q, w_beat_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic                  w_err_q, w_err_d, w_wr_en_s, w_last_s;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, r_ld_addr_s;
    logic [7:0]            ar_len_q, ar_len_d, r_beat_q, r_beat_d;
    logic [1:0]            ar_burst_q, ar_burst_d, r_ld_burst_s;
    logic                  r_load_s, r_ld_last_s;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // State and output registers for both engines
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            w_state_q <= W_IDLE;  aw_id_q <= '0;  aw_addr_q <= '0;  aw_len_q <= 8'd0;
            aw_burst_q <= 2'b00;  w_beat_q <= 8'd0;  w_err_q <= 1'b0;
            awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;  bid_q <= '0;  bresp_q <= 2'b00;
            r_state_q <= R_IDLE;  ar_id_q <= '0;  ar_addr_q <= '0;  ar_len_q <= 8'd0;
            ar_burst_q <= 2'b00;  r_beat_q <= 8'd0;
            arready_q <= 1'b0;  rvalid_q <= 1'b0;  rlast_q <= 1'b0;  rid_q <= '0;
            rdata_q <= '0;  rresp_q <= 2'b00;
        end else begin
            w_state_q <= w_state_d;  aw_id_q <= aw_id_d;  aw_addr_q <= aw_addr_d;  aw_len_q <= aw_len_d;
            aw_burst_q <= aw_burst_d;  w_beat_q <= w_beat_d;  w_err_q <= w_err_d;
            awready_q <= awready_d;  wready_q <= wready_d;  bvalid_q <= bvalid_d;  bid_q <= bid_d;  bresp_q <= bresp_d;
            r_state_q <= r_state_d;  ar_id_q <= ar_id_d;  ar_addr_q <= ar_addr_d;  ar_len_q <= ar_len_d;
            ar_burst_q <= ar_burst_d;  r_beat_q <= r_beat_d;
            arready_q <= arready_d;  rvalid_q <= rvalid_d;  rlast_q <= rlast_d;  rid_q <= rid_d;
            rdata_q <= rdata_d;  rresp_q <= rresp_d;
        end
    end

    // Byte-enabled memory write; contents survive reset
    always_ff @(posedge PCLK) begin
        if (!PRESET && w_wr_en_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WSTRB[i]) begin
                    mem[mem_idx(aw_addr_q)][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    // Write engine next state: burst length always comes from AWLEN, WLAST only flags errors
    always_comb begin
        w_state_d = w_state_q;  aw_id_d = aw_id_q;  aw_addr_d = aw_addr_q;  aw_len_d = aw_len_q;
        aw_burst_d = aw_burst_q;  w_beat_d = w_beat_q;  w_err_d = w_err_q;
        w_wr_en_s = 1'b0;
        w_last_s  = (w_beat_q == aw_len_q);
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    aw_id_d = AWID;  aw_addr_d = AWADDR;  aw_len_d = AWLEN;  aw_burst_d = AWBURST;
                    w_beat_d = 8'd0;  w_err_d = 1'b0;  w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    w_wr_en_s = addr_ok(aw_addr_q, aw_burst_q);
                    if (!w_wr_en_s || (WLAST != w_last_s)) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_err_d = w_err_q;
                    end
                    if (w_last_s) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d  = w_beat_q + 8'd1;
                        aw_addr_d = next_addr(aw_addr_q, aw_burst_q);
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write engine outputs, registered from the next state
    always_comb begin
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        if (w_state_d == W_RESP) begin
            bid_d   = aw_id_d;
            bresp_d = w_err_d ? RESP_SLVERR : RESP_OKAY;
        end else begin
            bid_d   = '0;
            bresp_d = RESP_OKAY;
        end
    end

    // Read engine next state and which beat (if any) to load this edge
    always_comb begin
        r_state_d = r_state_q;  ar_id_d = ar_id_q;  ar_addr_d = ar_addr_q;  ar_len_d = ar_len_q;
        ar_burst_d = ar_burst_q;  r_beat_d = r_beat_q;
        r_load_s = 1'b0;  r_ld_addr_s = ar_addr_q;  r_ld_burst_s = ar_burst_q;  r_ld_last_s = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    ar_id_d = ARID;  ar_addr_d = ARADDR;  ar_len_d = ARLEN;  ar_burst_d = ARBURST;
                    r_beat_d = 8'd0;  r_state_d = R_DATA;
                    r_load_s = 1'b1;  r_ld_addr_s = ARADDR;  r_ld_burst_s = ARBURST;
                    r_ld_last_s = (ARLEN == 8'd0);
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (RREADY && (r_beat_q == ar_len_q)) begin
                    r_state_d = R_IDLE;
                end else if (RREADY) begin
                    r_beat_d    = r_beat_q + 8'd1;
                    ar_addr_d   = next_addr(ar_addr_q, ar_burst_q);
                    r_load_s    = 1'b1;
                    r_ld_addr_s = ar_addr_d;
                    r_ld_last_s = (r_beat_d == ar_len_q);
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read engine outputs; memory is read before this edge's write lands
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        if (r_load_s) begin
            rid_d   = ar_id_d;
            rlast_d = r_ld_last_s;
            if (addr_ok(r_ld_addr_s, r_ld_burst_s)) begin
                rdata_d = mem[mem_idx(r_ld_addr_s)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end else if (r_state_d == R_IDLE) begin
            rid_d = '0;  rlast_d = 1'b0;  rdata_d = '0;  rresp_d = RESP_OKAY;
        end else begin
            rid_d = rid_q;  rlast_d = rlast_q;  rdata_d = rdata_q;  rresp_d = rresp_q;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: directed scenarios plus randomized bursts checked
// against a flat word-array model of the memory.
module tb_axi_slave_mem;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem_m [1024];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    always #5 PCLK = ~PCLK;

    axi_slave_mem dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    function automatic logic beat_ok(input logic [15:0] a, input logic [1:0] b);
        return (int'(a) / 4 < 1024) && (b == 2'b00 || b == 2'b01);
    endfunction

    function automatic logic [15:0] nxt(input logic [15:0] a, input logic [1:0] b);
        return (b == 2'b01) ? a + 16'd4 : a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input int len, input logic [1:0] burst,
                            input int early, input logic [3:0] id);
        logic [15:0] a;
        logic        err, wl;
        int          n;
        a = addr;
        err = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wl = (early >= 0) ? (b == early) : (b == len);
            if (beat_ok(a, burst)) begin
                for (int i = 0; i < 4; i++)
                    if (ws[b][i]) mem_m[int'(a) / 4][8*i +: 8] = wd[b][8*i +: 8];
            end else begin
                err = 1'b1;
            end
            if (wl != (b == len)) err = 1'b1;
            a = nxt(a, burst);
        end
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
        chk("awready", AWREADY, 1);
        @(negedge PCLK);
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            WDATA = wd[b]; WSTRB = ws[b];
            WLAST = (early >= 0) ? (b == early) : (b == len);
            WVALID = 1'b1;
            n = 0;
            while (WREADY !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
            chk("wready", WREADY, 1);
            @(negedge PCLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge PCLK);
        n = 0;
        while (BVALID !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
        chk("bvalid", BVALID, 1);
        chk("bresp", BRESP, err ? 2'b10 : 2'b00);
        chk("bid", BID, id);
        BREADY = 1'b1;
        @(negedge PCLK);
        BREADY = 1'b0;
        chk("bvalid_clr", BVALID, 0);
    endtask

    task automatic do_read(input logic [15:0] addr, input int len, input logic [1:0] burst,
                           input logic [3:0] id, input int stall_beat, input int stall_cyc, input int rnd_stall);
        logic [15:0] a;
        logic [31:0] exp_d, hold_d;
        logic        ok;
        int          n, st;
        a = addr;
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
        chk("arready", ARREADY, 1);
        @(negedge PCLK);
        ARVALID = 1'b0;
        chk("rvalid_lat1", RVALID, 1);
        for (int b = 0; b <= len; b++) begin
            ok = beat_ok(a, burst);
            exp_d = ok ? mem_m[int'(a) / 4] : 32'd0;
            n = 0;
            while (RVALID !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
            chk("rvalid", RVALID, 1);
            chk("rdata", RDATA, exp_d);
            chk("rresp", RRESP, ok ? 2'b00 : 2'b10);
            chk("rlast", RLAST, (b == len));
            chk("rid", RID, id);
            st = (b == stall_beat) ? stall_cyc : (rnd_stall != 0 ? $urandom_range(0, 2) : 0);
            if (st > 0) begin
                RREADY = 1'b0;
                hold_d = RDATA;
                repeat (st) begin
                    @(negedge PCLK);
                    chk("stall_rvalid", RVALID, 1);
                    chk("stall_rdata", RDATA, hold_d);
                    chk("stall_rlast", RLAST, (b == len));
                end
            end
            RREADY = 1'b1;
            @(negedge PCLK);
            a = nxt(a, burst);
        end
        RREADY = 1'b0;
        chk("rvalid_end", RVALID, 0);
        chk("arready_end", ARREADY, 1);
    endtask

    initial begin
        PRESET = 1'b1;
        AWID = 4'd0; AWADDR = 16'd0; AWLEN = 8'd0; AWBURST = 2'b00; AWVALID = 1'b0;
        WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = 4'd0; ARADDR = 16'd0; ARLEN = 8'd0; ARBURST = 2'b00; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rel_awready", AWREADY, 1);
        chk("rel_arready", ARREADY, 1);

        // Fill the whole memory so every model word is known (also exercises 256-beat bursts)
        for (int blk = 0; blk < 4; blk++) begin
            for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
            do_write(16'(blk * 1024), 255, 2'b01, -1, 4'(blk));
        end
        do_read(16'h0C00, 255, 2'b01, 4'd9, -1, 0, 0);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(16'h0010, 0, 2'b01, -1, 4'd3);
        do_read(16'h0010, 0, 2'b01, 4'd5, -1, 0, 0);

        for (int b = 0; b < 4; b++) begin wd[b] = 32'hFFFFFFFF; ws[b] = 4'hF; end
        do_write(16'h0100, 3, 2'b01, -1, 4'd1);
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        ws[0] = 4'hF;  ws[1] = 4'h3;  ws[2] = 4'hF;  ws[3] = 4'hF;
        do_write(16'h0100, 3, 2'b01, -1, 4'd2);
        chk("strb_model", mem_m[64 + 1], 32'hFFFF0002);
        do_read(16'h0100, 3, 2'b01, 4'd4, 1, 5, 0);

        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
        ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'hF;
        do_write(16'h0040, 2, 2'b00, -1, 4'd6);
        do_read(16'h0040, 1, 2'b00, 4'd7, -1, 0, 0);

        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(16'h1000, 0, 2'b01, -1, 4'd8);
        do_read(16'h0000, 0, 2'b01, 4'd8, -1, 0, 0);
        do_read(16'h1000, 1, 2'b01, 4'd2, -1, 0, 0);
        do_read(16'h0000, 2, 2'b10, 4'd3, -1, 0, 0);

        for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        do_write(16'h0300, 3, 2'b01, 1, 4'd10);
        do_read(16'h0300, 3, 2'b01, 4'd11, -1, 0, 0);

        for (int it = 0; it < 25; it++) begin
            logic [15:0] a;
            logic [1:0]  bt;
            int          ln;
            a  = ($urandom_range(0, 7) == 0) ? 16'(32'hFF0 + 32'($urandom_range(0, 8)) * 4)
                                             : 16'($urandom_range(0, 1023) * 4);
            bt = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            ln = $urandom_range(0, 7);
            for (int b = 0; b <= ln; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
            do_write(a, ln, bt, -1, 4'($urandom));
            do_read(a, $urandom_range(0, 7), 2'($urandom_range(0, 1)), 4'($urandom), -1, 0, 1);
        end

        // Reset while beat 2 of an 8-beat read is on the bus
        ARID = 4'd12; ARADDR = 16'h0200; ARLEN = 8'd7; ARBURST = 2'b01; ARVALID = 1'b1;
        @(negedge PCLK);
        ARVALID = 1'b0;
        RREADY = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("pre_rst_rdata", RDATA, mem_m[128 + 2]);
        PRESET = 1'b1;
        RREADY = 1'b0;
        @(negedge PCLK);
        chk("mid_rst_awready", AWREADY, 0);
        chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_b", {BVALID, BID, BRESP}, 0);
        chk("mid_rst_arready", ARREADY, 0);
        chk("mid_rst_r", {RVALID, RLAST, RRESP, RID}, 0);
        chk("mid_rst_rdata", RDATA, 0);
        PRESET = 1'b0;
        RREADY = 1'b1;
        @(negedge PCLK);
        chk("post_rst_awready", AWREADY, 1);
        chk("post_rst_arready", ARREADY, 1);
        repeat (3) begin
            chk("post_rst_rvalid", RVALID, 0);
            @(negedge PCLK);
        end
        RREADY = 1'b0;
        do_read(16'h0200, 1, 2'b01, 4'd13, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
